sobel_frame_sequencer: RTL and testbench

Frame-level controller for the Sobel edge-detection path. Latches host configuration (filter enable, threshold) only at frame boundaries and counts input pixels consumed per frame. After a frame it waits for the output buffer to drain, then pulses the pixel-control flush. Also provides abort, watchdog timeout, continuous-run and frame-completion status.

---
 rtl/sobel_frame_sequencer_if.sv | 40 ++++
 rtl/sobel_frame_sequencer.sv | 173 +++++++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_frame_sequencer_if.sv
// Host/datapath signal bundle for the Sobel frame sequencer.
// The master side drives the requests, configuration and datapath strobes.
// The slave side is the sequencer, which returns latched config and status.
interface sobel_frame_sequencer_if #(
  parameter int LINE_LENGTH = 640,
  parameter int LINE_NUM    = 480
);
  localparam int PIX_W = $clog2(LINE_LENGTH * LINE_NUM + 1);

  logic             i_start;
  logic             i_stop;
  logic             i_continuous;
  logic             i_cfg_enable;
  logic [23:0]      i_cfg_threshold;
  logic             i_pix_rd;
  logic             i_obuf_empty;
  logic             o_enable;
  logic [23:0]      o_threshold;
  logic             o_flush;
  logic             o_busy;
  logic             o_frame_done;
  logic             o_abort;
  logic             o_abort_code;
  logic [PIX_W-1:0] o_pix_cnt;
  logic [15:0]      o_frame_cnt;

  modport master (
    output i_start, i_stop, i_continuous, i_cfg_enable, i_cfg_threshold,
           i_pix_rd, i_obuf_empty,
    input  o_enable, o_threshold, o_flush, o_busy, o_frame_done, o_abort,
           o_abort_code, o_pix_cnt, o_frame_cnt
  );

  modport slave (
    input  i_start, i_stop, i_continuous, i_cfg_enable, i_cfg_threshold,
           i_pix_rd, i_obuf_empty,
    output o_enable, o_threshold, o_flush, o_busy, o_frame_done, o_abort,
           o_abort_code, o_pix_cnt, o_frame_cnt
  );
endinterface

// File: rtl/sobel_frame_sequencer.sv
// Frame-level controller for the Sobel edge-detection path.
// Latches host configuration at frame start, counts consumed pixels, waits
// for the output buffer to drain, then holds the pixel-control flush.
// Stop requests and a pixel-progress watchdog abort the frame through FLUSH.
module sobel_frame_sequencer #(
  parameter int LINE_LENGTH  = 640,
  parameter int LINE_NUM     = 480,
  parameter int FLUSH_CYCLES = 4,
  parameter int TIMEOUT      = 65536
) (
  input  logic                    CLK,
  input  logic                    RST,
  sobel_frame_sequencer_if.slave  bus
);

  localparam int FRAME_PIXELS = LINE_LENGTH * LINE_NUM;
  localparam int PIX_W        = $clog2(FRAME_PIXELS + 1);
  localparam int WD_W         = $clog2(TIMEOUT);
  localparam int FL_W         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_FLUSH
  } state_t;

  state_t           state_q, state_d;
  logic             enable_q, enable_d;
  logic [23:0]      threshold_q, threshold_d;
  logic             flush_q, flush_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             abort_q, abort_d;
  logic             abort_code_q, abort_code_d;
  logic             aborted_q, aborted_d;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic [FL_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             timeout_hit;

  // Next-state logic: stop beats timeout beats frame completion, and every
  // registered output is derived from the state being entered.
  always_comb begin
    state_d      = state_q;
    enable_d     = enable_q;
    threshold_d  = threshold_q;
    frame_done_d = 1'b0;
    abort_d      = 1'b0;
    abort_code_d = abort_code_q;
    aborted_d    = aborted_q;
    pix_cnt_d    = pix_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    wdog_d       = wdog_q;
    flush_cnt_d  = flush_cnt_q;
    timeout_hit  = (wdog_q == WD_LAST);

    case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        enable_d    = bus.i_cfg_enable;
        threshold_d = bus.i_cfg_threshold;
        pix_cnt_d   = '0;
        wdog_d      = '0;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (bus.i_stop || timeout_hit) begin
          state_d      = ST_FLUSH;
          aborted_d    = 1'b1;
          abort_d      = 1'b1;
          abort_code_d = !bus.i_stop;
          flush_cnt_d  = '0;
        end else if (bus.i_pix_rd) begin
          pix_cnt_d = pix_cnt_q + 1'b1;
          wdog_d    = '0;
          if (pix_cnt_q == PIX_LAST) begin
            state_d = ST_DRAIN;
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        wdog_d = wdog_q + 1'b1;
        if (bus.i_stop || timeout_hit) begin
          state_d      = ST_FLUSH;
          aborted_d    = 1'b1;
          abort_d      = 1'b1;
          abort_code_d = !bus.i_stop;
          flush_cnt_d  = '0;
        end else if (bus.i_obuf_empty) begin
          state_d     = ST_FLUSH;
          aborted_d   = 1'b0;
          flush_cnt_d = '0;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FL_LAST) begin
          if (aborted_q) begin
            state_d = ST_IDLE;
          end else begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 16'd1;
            state_d      = bus.i_continuous ? ST_LOAD : ST_IDLE;
          end
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    flush_d = (state_d == ST_FLUSH);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      enable_q     <= 1'b0;
      threshold_q  <= '0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      abort_q      <= 1'b0;
      abort_code_q <= 1'b0;
      aborted_q    <= 1'b0;
      pix_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      wdog_q       <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      threshold_q  <= threshold_d;
      flush_q      <= flush_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      abort_q      <= abort_d;
      abort_code_q <= abort_code_d;
      aborted_q    <= aborted_d;
      pix_cnt_q    <= pix_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      wdog_q       <= wdog_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.o_enable     = enable_q;
  assign bus.o_threshold  = threshold_q;
  assign bus.o_flush      = flush_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_abort      = abort_q;
  assign bus.o_abort_code = abort_code_q;
  assign bus.o_pix_cnt    = pix_cnt_q;
  assign bus.o_frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Directed bench for sobel_frame_sequencer with a small 4x3 frame.
// Frame-done and abort events are predicted into a queue as stimulus is
// applied and matched by a monitor whenever the sequencer reports one.
module tb_sobel_frame_sequencer;

  localparam int LL = 4;
  localparam int LN = 3;
  localparam int FC = 2;
  localparam int TO = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    bit isAbort;
    bit code;
    bit chkPix;
    int pixCnt;
    int frameCnt;
  } evt_t;

  evt_t expQ[$];
  evt_t monEv;

  sobel_frame_sequencer_if #(.LINE_LENGTH(LL), .LINE_NUM(LN)) bus ();

  sobel_frame_sequencer #(
    .LINE_LENGTH (LL),
    .LINE_NUM    (LN),
    .FLUSH_CYCLES(FC),
    .TIMEOUT     (TO)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  // Free-running 10 ns clock.
  always #5 CLK = ~CLK;

  // Single comparison point shared by the directed steps and the monitor.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive one cycle worth of control inputs and clock them in.
  task automatic applyStimulus(input logic start, input logic stop,
                               input logic pixRd, input logic obufEmpty);
    bus.i_start      = start;
    bus.i_stop       = stop;
    bus.i_pix_rd     = pixRd;
    bus.i_obuf_empty = obufEmpty;
    tick();
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic startFrame();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic expectEvent(input bit isAbort, input bit code, input bit chkPix,
                             input int pix, input int frm);
    evt_t e;
    e.isAbort  = isAbort;
    e.code     = code;
    e.chkPix   = chkPix;
    e.pixCnt   = pix;
    e.frameCnt = frm;
    expQ.push_back(e);
  endtask

  // Monitor: every frame-done or abort pulse must match the next prediction.
  always @(posedge CLK) begin
    #1;
    if (bus.o_frame_done === 1'b1 || bus.o_abort === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected event", 32'({bus.o_frame_done, bus.o_abort}), 32'd0);
      end else begin
        monEv = expQ.pop_front();
        checkOutput("event abort flag", 32'(bus.o_abort), 32'(monEv.isAbort));
        checkOutput("event done flag", 32'(bus.o_frame_done), 32'(!monEv.isAbort));
        if (monEv.isAbort) checkOutput("event abort code", 32'(bus.o_abort_code), 32'(monEv.code));
        if (monEv.chkPix) checkOutput("event pix_cnt", 32'(bus.o_pix_cnt), 32'(monEv.pixCnt));
        checkOutput("event frame_cnt", 32'(bus.o_frame_cnt), 32'(monEv.frameCnt));
      end
    end
  end

  // Directed scenario sequence.
  initial begin
    bus.i_start = 0; bus.i_stop = 0; bus.i_continuous = 0; bus.i_cfg_enable = 0;
    bus.i_cfg_threshold = 24'h0; bus.i_pix_rd = 0; bus.i_obuf_empty = 0;

    RST = 1'b0;
    idle(2);
    RST = 1'b1;
    checkOutput("reset enable", 32'(bus.o_enable), 32'd0);
    checkOutput("reset threshold", 32'(bus.o_threshold), 32'd0);
    checkOutput("reset flush", 32'(bus.o_flush), 32'd0);
    checkOutput("reset busy", 32'(bus.o_busy), 32'd0);
    checkOutput("reset pix_cnt", 32'(bus.o_pix_cnt), 32'd0);
    checkOutput("reset frame_cnt", 32'(bus.o_frame_cnt), 32'd0);
    checkOutput("reset abort_code", 32'(bus.o_abort_code), 32'd0);

    $display("[TB] normal frame");
    bus.i_cfg_enable = 1'b1;
    bus.i_cfg_threshold = 24'h000100;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("busy after start", 32'(bus.o_busy), 32'd1);
    checkOutput("enable not yet latched", 32'(bus.o_enable), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("enable latched", 32'(bus.o_enable), 32'd1);
    checkOutput("threshold latched", 32'(bus.o_threshold), 32'h100);
    pixels(12);
    checkOutput("pix_cnt full", 32'(bus.o_pix_cnt), 32'd12);
    pixels(2);
    checkOutput("pix_cnt saturated in drain", 32'(bus.o_pix_cnt), 32'd12);
    checkOutput("no flush while draining", 32'(bus.o_flush), 32'd0);
    expectEvent(1'b0, 1'b0, 1'b1, 12, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("flush cycle 1", 32'(bus.o_flush), 32'd1);
    idle(1);
    checkOutput("flush cycle 2", 32'(bus.o_flush), 32'd1);
    idle(1);
    checkOutput("flush released", 32'(bus.o_flush), 32'd0);
    checkOutput("frame_done pulse", 32'(bus.o_frame_done), 32'd1);
    checkOutput("frame_cnt 1", 32'(bus.o_frame_cnt), 32'd1);
    checkOutput("idle busy", 32'(bus.o_busy), 32'd0);
    pixels(1);
    checkOutput("pix_cnt ignores idle reads", 32'(bus.o_pix_cnt), 32'd12);
    checkOutput("frame_done one cycle", 32'(bus.o_frame_done), 32'd0);

    $display("[TB] config isolation and continuous run");
    bus.i_continuous = 1'b1;
    startFrame();
    pixels(6);
    bus.i_cfg_threshold = 24'h0000FF;
    pixels(6);
    checkOutput("threshold isolated", 32'(bus.o_threshold), 32'h100);
    expectEvent(1'b0, 1'b0, 1'b1, 12, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    checkOutput("busy across frames", 32'(bus.o_busy), 32'd1);
    idle(1);
    checkOutput("new threshold loaded", 32'(bus.o_threshold), 32'hFF);
    checkOutput("pix_cnt cleared on load", 32'(bus.o_pix_cnt), 32'd0);

    $display("[TB] stop after five pixels");
    pixels(5);
    expectEvent(1'b1, 1'b0, 1'b1, 5, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("stop abort pulse", 32'(bus.o_abort), 32'd1);
    checkOutput("stop abort code", 32'(bus.o_abort_code), 32'd0);
    checkOutput("stop pix_cnt held", 32'(bus.o_pix_cnt), 32'd5);
    checkOutput("stop flush", 32'(bus.o_flush), 32'd1);
    idle(2);
    checkOutput("aborted idles despite continuous", 32'(bus.o_busy), 32'd0);
    checkOutput("frame_cnt after stop", 32'(bus.o_frame_cnt), 32'd2);
    bus.i_continuous = 1'b0;

    $display("[TB] stop on last pixel");
    startFrame();
    pixels(11);
    expectEvent(1'b1, 1'b0, 1'b0, 0, 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("last-pixel stop abort", 32'(bus.o_abort), 32'd1);
    idle(3);
    checkOutput("no completion after stop", 32'(bus.o_frame_cnt), 32'd2);

    $display("[TB] watchdog in run");
    startFrame();
    pixels(3);
    idle(7);
    checkOutput("no abort before timeout", 32'(bus.o_flush), 32'd0);
    expectEvent(1'b1, 1'b1, 1'b1, 3, 2);
    idle(1);
    checkOutput("run timeout abort", 32'(bus.o_abort), 32'd1);
    checkOutput("run timeout code", 32'(bus.o_abort_code), 32'd1);
    idle(2);

    $display("[TB] watchdog in drain, start ignored in run");
    startFrame();
    pixels(4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    pixels(7);
    checkOutput("start ignored in run", 32'(bus.o_pix_cnt), 32'd12);
    idle(7);
    checkOutput("drain waits", 32'(bus.o_flush), 32'd0);
    expectEvent(1'b1, 1'b1, 1'b1, 12, 2);
    idle(1);
    checkOutput("drain timeout abort", 32'(bus.o_abort), 32'd1);
    idle(2);
    checkOutput("abort_code holds", 32'(bus.o_abort_code), 32'd1);
    checkOutput("idle after drain abort", 32'(bus.o_busy), 32'd0);

    $display("[TB] reset mid-run");
    startFrame();
    pixels(7);
    checkOutput("pix_cnt before reset", 32'(bus.o_pix_cnt), 32'd7);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    checkOutput("mid reset pix_cnt", 32'(bus.o_pix_cnt), 32'd0);
    checkOutput("mid reset enable", 32'(bus.o_enable), 32'd0);
    checkOutput("mid reset threshold", 32'(bus.o_threshold), 32'd0);
    checkOutput("mid reset frame_cnt", 32'(bus.o_frame_cnt), 32'd0);
    checkOutput("mid reset abort_code", 32'(bus.o_abort_code), 32'd0);
    idle(1);
    checkOutput("no flush after reset", 32'(bus.o_flush), 32'd0);
    checkOutput("idle after reset", 32'(bus.o_busy), 32'd0);

    $display("[TB] frame counter wrap");
    dut.frame_cnt_q = 16'hFFFF;
    startFrame();
    pixels(12);
    expectEvent(1'b0, 1'b0, 1'b1, 12, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    checkOutput("frame_cnt wrapped", 32'(bus.o_frame_cnt), 32'd0);
    checkOutput("wrap frame_done", 32'(bus.o_frame_done), 32'd1);
    idle(2);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
